// File: rtl/s_axi_lite_regfile_if.sv
// AXI4-Lite bus bundle for the control register file: five channels, master drives requests.
interface s_axi_lite_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/s_axi_lite_regfile.sv
// AXI4-Lite register file: RW stored regs and RO live status regs, SLVERR on bad/RO writes.
// Response one edge after request latched; B/R held until ready, one outstanding write and read.
module s_axi_lite_regfile #(
  parameter int                             ADDR_WIDTH = 32,
  parameter int                             DATA_WIDTH = 32,
  parameter int                             NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = 8'h08,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALS = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  s_axi_lite_regfile_if.slave            s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic [NUM_REGS-1:0]            rd_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int SEL_W    = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // ---------------- write path ----------------
  w_state_t              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_d;
  logic                  aw_hs, w_hs, wr_commit, wr_ok;
  logic [SEL_W-1:0]      aw_sel;

  assign aw_hs  = s_axi.awvalid && awready_q;
  assign w_hs   = s_axi.wvalid && wready_q;
  assign aw_sel = aw_idx_q[SEL_W-1:0];
  // Whole upper address field is compared so out-of-range addresses never alias onto a reg.
  assign wr_ok  = (aw_idx_q < IDX_W'(NUM_REGS)) && !RO_MASK[aw_sel];

  always_comb begin
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    wr_commit  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_held_q && w_held_q) begin
          wr_commit = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          if (wr_ok) wr_pulse_d[aw_sel] = 1'b1;
          w_state_d = W_RESP;
        end else begin
          if (aw_hs) aw_held_d = 1'b1;
          if (w_hs)  w_held_d  = 1'b1;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_pulse  <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wr_pulse  <= wr_pulse_d;
      if (aw_hs) aw_idx_q <= s_axi.awaddr[ADDR_WIDTH-1:ADDR_LSB];
      if (w_hs) begin
        w_data_q <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
    end
  end

  always_ff @(posedge aclk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!aresetn) begin
        regs_q[i] <= RESET_VALS[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (wr_commit && wr_ok && (aw_sel == SEL_W'(i))) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (w_strb_q[b]) regs_q[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
        end
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t              r_state_q, r_state_d;
  logic                  ar_held_q, ar_held_d;
  logic [IDX_W-1:0]      ar_idx_q;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REGS-1:0]   rd_pulse_d;
  logic                  ar_hs;
  logic [SEL_W-1:0]      ar_sel;

  assign ar_hs  = s_axi.arvalid && arready_q;
  assign ar_sel = ar_idx_q[SEL_W-1:0];

  always_comb begin
    r_state_d  = r_state_q;
    ar_held_d  = ar_held_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rd_pulse_d = '0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_held_q) begin
          ar_held_d = 1'b0;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
          // regs_q is sampled before any same-edge write lands, so a colliding read sees the old value.
          if (ar_idx_q < IDX_W'(NUM_REGS)) begin
            rresp_d = RESP_OKAY;
            rdata_d = RO_MASK[ar_sel] ? status_in[ar_sel*DATA_WIDTH +: DATA_WIDTH] : regs_q[ar_sel];
            rd_pulse_d[ar_sel] = 1'b1;
          end else begin
            rresp_d = RESP_SLVERR;
            rdata_d = '0;
          end
        end else if (ar_hs) begin
          ar_held_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi.rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE) && !ar_held_d;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      ar_held_q <= 1'b0;
      ar_idx_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rd_pulse  <= '0;
    end else begin
      r_state_q <= r_state_d;
      ar_held_q <= ar_held_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rd_pulse  <= rd_pulse_d;
      if (ar_hs) ar_idx_q <= s_axi.araddr[ADDR_WIDTH-1:ADDR_LSB];
    end
  end

  // ---------------- outputs ----------------
  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] =
      RO_MASK[g] ? RESET_VALS[g*DATA_WIDTH +: DATA_WIDTH] : regs_q[g];
  end

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

endmodule
